// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the custom {sign, exp, frac} format.
// Holds the default field widths, the bias function, field slicing helpers
// and constant builders used by the multiplier and the planned adder.
// Fields are passed as 64-bit words together with their widths so that one
// set of helpers serves every parametrisation.
//
// Format notes:
//   exp == 0 encodes zero (fraction ignored), no denormals, no inf/NaN.
package fp_pkg;

  localparam int EXP_W_DEF  = 7;
  localparam int FRAC_W_DEF = 16;

  // Only RNE is implemented; the other encodings are reserved for future modes.
  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } round_mode_t;

  localparam round_mode_t ROUND_MODE = RND_RNE;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic fp_sign(input logic [63:0] x, input int exp_w, input int frac_w);
    return x[exp_w + frac_w];
  endfunction

  function automatic logic [63:0] fp_exp(input logic [63:0] x, input int exp_w, input int frac_w);
    return (x >> frac_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac(input logic [63:0] x, input int frac_w);
    return x & ((64'd1 << frac_w) - 64'd1);
  endfunction

  // Largest magnitude with the given sign: all-ones exponent and fraction.
  function automatic logic [63:0] fp_sat(input logic sign, input int exp_w, input int frac_w);
    return ({63'd0, sign} << (exp_w + frac_w)) | ((64'd1 << (exp_w + frac_w)) - 64'd1);
  endfunction

  // Signed zero: sign kept, exponent and fraction cleared.
  function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int frac_w);
    return {63'd0, sign} << (exp_w + frac_w);
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result channel of the pipelined FP multiplier.
//   in_valid/in_ready/in_a/in_b           : operand pair handshake
//   out_valid/out_ready/out_p             : result handshake
//   out_overflow/out_underflow            : result flags, qualified by out_valid
// master = producer/consumer side, slave = the multiplier.
interface fp_mul_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_overflow;
  logic         out_underflow;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_overflow, out_underflow
  );

endinterface

// File: rtl/fp_norm_round.sv
// Combinational normalise + round-to-nearest-even + range check.
// Takes the raw mantissa product and exponent sum of a multiply (or, later,
// the adder's aligned sum) and produces the final packed word and flags.
// Ports:
//   sign      : result sign
//   esum      : biased exponent sum, signed EXP_W+2 bits
//   prod      : {1,fa}*{1,fb}, 2*FRAC_W+2 bits
//   zero      : an operand was zero; forces signed zero, no flags
//   res       : packed result {sign, exp, frac}
//   overflow  : result saturated to the largest magnitude
//   underflow : result flushed to zero
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int BIAS   = fp_bias(EXP_W)
) (
  input  logic                       sign,
  input  logic signed [EXP_W+1:0]    esum,
  input  logic [2*FRAC_W+1:0]        prod,
  input  logic                       zero,
  output logic [EXP_W+FRAC_W:0]      res,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int F  = FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * FRAC_W + 2;
  localparam int W  = 1 + EXP_W + FRAC_W;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] MAX_E  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);

  logic [F-1:0]           m;
  logic [F-1:0]           m_r;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic                   carry;
  logic signed [EW-1:0]   e;
  logic signed [EW-1:0]   e_r;

  // A product of two values in [1,2) lies in [1,4); the top bit picks which
  // half, and that shifts both the kept mantissa window and the exponent.
  // Rounding carry out of the mantissa leaves m at zero (value 1.0) and bumps
  // the exponent. Range checks are applied after rounding so a rounding carry
  // can itself overflow. A zero operand overrides everything.
  always_comb begin
    m         = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    e         = '0;
    inc       = 1'b0;
    carry     = 1'b0;
    m_r       = '0;
    e_r       = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    res       = '0;

    if (prod[PW-1]) begin
      m      = prod[2*F:F+1];
      guard  = prod[F];
      sticky = |prod[F-1:0];
      e      = esum - BIAS_E + ONE_E;
    end else begin
      m      = prod[2*F-1:F];
      guard  = prod[F-1];
      sticky = |prod[F-2:0];
      e      = esum - BIAS_E;
    end

    inc          = guard && (sticky || m[0]);
    {carry, m_r} = {1'b0, m} + {{F{1'b0}}, inc};
    e_r          = carry ? (e + ONE_E) : e;

    res = {sign, e_r[EXP_W-1:0], m_r};
    if (zero) begin
      res = W'(fp_zero(sign, EXP_W, FRAC_W));
    end else if (e_r > MAX_E) begin
      res      = W'(fp_sat(sign, EXP_W, FRAC_W));
      overflow = 1'b1;
    end else if (e_r < ONE_E) begin
      res       = W'(fp_zero(sign, EXP_W, FRAC_W));
      underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control, round-to-nearest-even, zero handling and saturating overflow /
// flush-to-zero underflow.
//   S1: operands and zero flag
//   S2: sign, exponent sum, full mantissa product
//   S3: normalised/rounded result and flags (the output registers)
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : fp_mul_pipe_if.slave (operand and result handshakes, product, flags)
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int BIAS   = fp_bias(EXP_W)
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_pipe_if.slave  bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * FRAC_W + 2;

  // The whole pipe advances in lockstep: any stall at the output freezes
  // every stage, bubbles included. Reset forces in_ready high so upstream is
  // never blocked by a discarded result, but the valid bits are cleared so
  // nothing offered during reset is kept.
  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en || rst;

  logic                 in_zero;
  logic                 s1_valid;
  logic [W-1:0]         s1_a;
  logic [W-1:0]         s1_b;
  logic                 s1_zero;

  logic [EXP_W-1:0]     ea;
  logic [EXP_W-1:0]     eb;
  logic [FRAC_W-1:0]    fa;
  logic [FRAC_W-1:0]    fb;
  logic                 sign_c;
  logic signed [EW-1:0] esum_c;
  logic [PW-1:0]        prod_c;

  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [EW-1:0] s2_esum;
  logic [PW-1:0]        s2_prod;
  logic                 s2_zero;

  logic [W-1:0]         nr_p;
  logic                 nr_ov;
  logic                 nr_un;

  assign in_zero = (fp_exp(64'(bus.in_a), EXP_W, FRAC_W) == 64'd0) ||
                   (fp_exp(64'(bus.in_b), EXP_W, FRAC_W) == 64'd0);

  assign ea     = EXP_W'(fp_exp(64'(s1_a), EXP_W, FRAC_W));
  assign eb     = EXP_W'(fp_exp(64'(s1_b), EXP_W, FRAC_W));
  assign fa     = FRAC_W'(fp_frac(64'(s1_a), FRAC_W));
  assign fb     = FRAC_W'(fp_frac(64'(s1_b), FRAC_W));
  assign sign_c = fp_sign(64'(s1_a), EXP_W, FRAC_W) ^ fp_sign(64'(s1_b), EXP_W, FRAC_W);
  assign esum_c = $signed(EW'(ea)) + $signed(EW'(eb));
  assign prod_c = PW'({1'b1, fa}) * PW'({1'b1, fb});

  fp_norm_round #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W),
    .BIAS   (BIAS)
  ) u_norm_round (
    .sign      (s2_sign),
    .esum      (s2_esum),
    .prod      (s2_prod),
    .zero      (s2_zero),
    .res       (nr_p),
    .overflow  (nr_ov),
    .underflow (nr_un)
  );

  // Control path and output registers: these are the only state that needs
  // reset. The output data only loads with a real result so a bubble leaves
  // the last product visible behind a low out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid          <= 1'b0;
      s2_valid          <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.out_p         <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
    end else if (en) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_p         <= nr_p;
        bus.out_overflow  <= nr_ov;
        bus.out_underflow <= nr_un;
      end
    end
  end

  // Datapath registers: qualified by the valid bits, so they load freely
  // whenever the pipe advances and carry no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a    <= bus.in_a;
      s1_b    <= bus.in_b;
      s1_zero <= in_zero;
      s2_sign <= sign_c;
      s2_esum <= esum_c;
      s2_prod <= prod_c;
      s2_zero <= s1_zero;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard testbench for fp_mul_pipe (EXP_W=7, FRAC_W=16).
// Stimulus pushes the expected response when an operand pair is accepted;
// an independent monitor pops and compares whenever a result transfers.
module tb_fp_mul_pipe;
  localparam int EXP_W  = 7;
  localparam int FRAC_W = 16;
  localparam int W      = 24;

  typedef struct {
    logic [W-1:0] p;
    logic         ov;
    logic         un;
    int           issue_cyc;
    bit           chk_lat;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rand_on = 1'b0;
  exp_t sb[$];

  fp_mul_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact integer product, then round by comparing the discarded
  // remainder with half an ulp.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint unsigned ma, mb, prod, q, rem, half;
    int e, sh;
    logic s;
    s = a[23] ^ b[23];
    r.ov = 1'b0; r.un = 1'b0; r.chk_lat = 1'b0; r.issue_cyc = 0; r.name = "random";
    if (a[22:16] == 7'd0 || b[22:16] == 7'd0) begin
      r.p = {s, 23'd0};
      return r;
    end
    ma   = longint'(a[15:0]) + 64'd65536;
    mb   = longint'(b[15:0]) + 64'd65536;
    prod = ma * mb;
    e    = int'(a[22:16]) + int'(b[22:16]) - 63;
    if (prod >= (64'd1 << 33)) begin sh = 17; e++; end
    else sh = 16;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 17)) begin q = q >> 1; e++; end
    if (e > 127) begin r.p = {s, 23'h7FFFFF}; r.ov = 1'b1; end
    else if (e < 1) begin r.p = {s, 23'd0}; r.un = 1'b1; end
    else r.p = {s, 7'(e), 16'(q)};
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] p, input logic ov, input logic un, input string name);
    exp_t r;
    r.p = p; r.ov = ov; r.un = un; r.issue_cyc = 0; r.chk_lat = 1'b1; r.name = name;
    return r;
  endfunction

  function automatic logic [W-1:0] randOperand();
    logic [6:0] ex;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      ex = 7'd0;
    else if (sel <= 3) ex = 7'($urandom_range(1, 127));
    else               ex = 7'($urandom_range(40, 90));
    return {1'($urandom_range(0, 1)), ex, 16'($urandom_range(0, 65535))};
  endfunction

  // Holds in_valid with the pair until accepted; leaves in_valid high so
  // consecutive calls issue back-to-back. Returns at posedge+1.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t ex);
    int waited = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!done && waited < 500) begin
      @(negedge clk);
      waited++;
      if (bus.in_ready === 1'b1 && rst === 1'b0) begin
        ex.issue_cyc = cyc;
        sb.push_back(ex);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout %s: got no in_ready, expected acceptance", ex.name);
    end
    @(posedge clk); #1;
  endtask

  task automatic waitDrain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares each transferred result with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_result: got %h, expected no output", bus.out_p);
        end else begin
          e = sb.pop_front();
          checkOutput(e.name, {6'd0, bus.out_overflow, bus.out_underflow, bus.out_p},
                              {6'd0, e.ov, e.un, e.p});
          if (e.chk_lat) checkOutput({e.name, "_latency"}, 32'(cyc - e.issue_cyc), 32'd3);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [W-1:0] da [11] = '{24'h3F8000, 24'hC00000, 24'h3F0001, 24'h3F0001, 24'h7F0000,
                            24'h010000, 24'h800000, 24'hFF0000, 24'h3F8000, 24'h7F0000, 24'h010000};
  logic [W-1:0] db [11] = '{24'h3F8000, 24'h3F8000, 24'h3F8000, 24'h3F0001, 24'h7F0000,
                            24'h010000, 24'h3F0000, 24'h7F0000, 24'h3F5555, 24'h3F0000, 24'h3F0000};
  logic [W-1:0] dp [11] = '{24'h402000, 24'hC08000, 24'h3F8002, 24'h3F0002, 24'h7FFFFF,
                            24'h000000, 24'h800000, 24'hFFFFFF, 24'h400000, 24'h7F0000, 24'h010000};
  logic dov [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic dun [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  string dname [11] = '{"mul_1p5_1p5", "mul_neg2_1p5", "rne_tie_up", "sticky_round_down",
                        "overflow_pos", "underflow", "zero_operand", "overflow_neg",
                        "round_carry", "max_exp_exact", "min_exp_exact"};

  logic [W-1:0] bpa [5] = '{24'h3F8000, 24'h400000, 24'hC04000, 24'h3E0000, 24'h412345};
  logic [W-1:0] bpb [5] = '{24'h3F8000, 24'h3FC000, 24'h3F2000, 24'h400000, 24'hBF5555};

  initial begin
    logic [W-1:0] ra, rb;
    exp_t ex;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {6'd0, bus.out_overflow, bus.out_underflow, bus.out_p}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one at a time with latency checked
    for (int i = 0; i < 11; i++) begin
      applyStimulus(da[i], db[i], mk(dp[i], dov[i], dun[i], dname[i]));
      bus.in_valid = 1'b0;
      waitDrain(20);
    end

    // Backpressure: 5 back-to-back pairs, output stalled from cycle 2
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ex = model(bpa[i], bpb[i]);
          ex.name = "backpressure";
          applyStimulus(bpa[i], bpb[i], ex);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("drain_streaming", {31'd0, bus.out_valid}, 32'd1);
        end
      end
    join
    waitDrain(20);

    // Random backpressure with continuous issue
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = randOperand();
          rb = randOperand();
          applyStimulus(ra, rb, model(ra, rb));
        end
        bus.in_valid = 1'b0;
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    waitDrain(50);

    // Reset with three results in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex = model(bpa[i], bpb[i]);
      applyStimulus(bpa[i], bpb[i], ex);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_during_reset", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("flush_outputs", {6'd0, bus.out_overflow, bus.out_underflow, bus.out_p}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(24'h3F8000, 24'h3F8000, mk(24'h402000, 1'b0, 1'b0, "after_reset"));
    bus.in_valid = 1'b0;
    waitDrain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier for the custom sign/exponent/fraction format.
- Supersedes the fixed 1/7/16 multiply chain.
- Adds generic widths, valid/ready flow control with backpressure, round-to-nearest-even, zero handling, and saturating overflow / flush-to-zero underflow with flags.
- Sits between operand producers and the accumulate/output datapath.

Parameters:
- EXP_W, 7: exponent width.
- FRAC_W, 16: stored fraction width; the hidden 1 is not stored.
- BIAS, 2**(EXP_W-1)-1: exponent offset, 63 at default.
- W, 1+EXP_W+FRAC_W: word width (localparam), 24 at default.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts a pair this cycle
- in_a  in  W  operand A: {sign, exp, frac}
- in_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_p  out  W  product
- out_overflow  out  1  result saturated; qualified by out_valid
- out_underflow  out  1  result flushed to zero; qualified by out_valid

Behaviour:
- Encoding:
  - exp==0 means zero, whatever the fraction. No denormals.
  - No inf/NaN encoding. exp 1..2^EXP_W-1 are all normal values.
- Pipeline: 3 register stages.
  - S1 captures operands and the zero flag.
  - S2 forms sign = sa^sb, esum = ea+eb (EXP_W+2 bits, signed) and P = {1,fa}*{1,fb} (2*FRAC_W+2 bits).
  - S3 normalises, rounds, applies range checks and drives the outputs.
  - Latency is 3 cycles from accept to out_valid when no stall occurs.
- Handshake:
  - en = !out_valid || out_ready.
  - in_ready = en, combinational.
  - A transfer happens on in_valid&&in_ready, and on out_valid&&out_ready.
  - When en=0, every stage holds, including valid bits. No data is lost or reordered.
  - Bubbles advance only while en=1. No bubble collapsing.
  - in_ready must not depend on in_valid.
- Normalise:
  - If P[MSB]=1: m = P[2F:F+1], guard = P[F], sticky = |P[F-1:0], e = esum-BIAS+1.
  - Else: m = P[2F-1:F], guard = P[F-1], sticky = |P[F-2:0], e = esum-BIAS.
  - F = FRAC_W.
- Round to nearest even:
  - Increment m when guard && (sticky || m[0]).
  - If the increment carries out of m, m = 0 and e += 1.
- Range checks (result exponent e, signed):
  - e > 2^EXP_W-1: output {sign, all-ones exp, all-ones frac}, out_overflow=1.
  - e < 1: output {sign, 0, 0}, out_underflow=1.
  - Zero operand (either exp==0): output {sign, 0, 0}, both flags 0. This takes priority over the range checks.
- Flags are valid only with out_valid. They hold with the data while stalled.
- Reset:
  - out_valid=0, out_p=0, out_overflow=0, out_underflow=0, all internal valid bits 0, the cycle after rst is sampled high.
  - Applies mid-operation: in-flight data is discarded.
  - While rst=1, in_ready=1 but nothing is captured.
- Datapath registers need no reset; only the valid bits and the output registers are reset.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W/FRAC_W defaults and the bias function.
  - Field slicing helpers (sign/exp/frac).
  - Saturation/zero constant builders.
  - Rounding-mode enum, reserved for future modes; only RNE is implemented here.
- One sub-module: fp_norm_round. It is combinational normalise + RNE + range check, instantiated before the S3 registers. Reused by the planned adder.

Test Plan (defaults EXP_W=7, FRAC_W=16):
- 0x3F8000 * 0x3F8000 (1.5*1.5) -> 0x402000 (2.25), no flags, out_valid exactly 3 cycles after accept.
- 0xC00000 * 0x3F8000 (-2*1.5) -> 0xC08000; 0x3F0001 * 0x3F8000 (tie case) -> 0x3F8002; 0x3F0001 * 0x3F0001 -> 0x3F0002 (sticky-only, rounded down).
- Exp 127 * exp 127 -> 0x7FFFFF, out_overflow=1. Exp 1 * exp 1 -> 0x000000, out_underflow=1. 0x800000 * 0x3F0000 -> 0x800000, no flags.
- Back-to-back issue of 5 pairs with out_ready=0 from cycle 2 -> in_ready drops once the output is full, no result lost. Release out_ready -> all 5 results emerge in order, 1 per cycle.
- Random out_ready toggling with continuous in_valid over 1000 ops -> scoreboard matches a reference model bit-exactly, flags included.
- rst asserted 1 cycle while 3 ops are in flight -> out_valid=0 the next cycle, no stale result appears afterwards, and the next accepted op returns correctly 3 cycles later.
